// File: rtl/vip_frame_ctrl_if.sv
// Bus bundle for the frame controller: input video timing, the config
// valid/ready port, and the per-frame status/active-config outputs.
//
// Handshake: a config transfer happens on a rising clk edge where
// cfg_valid and cfg_ready are both 1. The requester keeps cfg_valid,
// cfg_mode and cfg_threshold stable until that edge; cfg_ready never
// depends combinationally on cfg_valid.
interface vip_frame_ctrl_if;
  logic       pre_frame_vsync;
  logic       pre_frame_href;
  logic       pre_frame_de;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_threshold;
  logic [1:0] act_mode;
  logic [7:0] act_threshold;
  logic       frame_done;
  logic       frame_err;
  logic [15:0] frame_cnt;
  logic [11:0] last_lines;
  logic [1:0] dbg_state;

  modport master (
    output pre_frame_vsync, pre_frame_href, pre_frame_de,
    output cfg_valid, cfg_mode, cfg_threshold,
    input  cfg_ready, act_mode, act_threshold,
    input  frame_done, frame_err, frame_cnt, last_lines, dbg_state
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_href, pre_frame_de,
    input  cfg_valid, cfg_mode, cfg_threshold,
    output cfg_ready, act_mode, act_threshold,
    output frame_done, frame_err, frame_cnt, last_lines, dbg_state
  );
endinterface

// File: rtl/vip_frame_ctrl.sv
// Frame-synchronous controller for the RGB->Y / Sobel chain.
// Holds one pending config entry, applies it only at frame start, and
// checks line/pixel counts of every frame, reporting status at frame end.
module vip_frame_ctrl #(
  parameter int H_PIXELS      = 640,
  parameter int V_LINES       = 480,
  parameter int DEF_THRESHOLD = 128,
  parameter int DEF_MODE      = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vip_frame_ctrl_if.slave bus
);

  localparam logic [11:0] LP_H       = 12'(H_PIXELS);
  localparam logic [11:0] LP_V       = 12'(V_LINES);
  localparam logic [11:0] LP_CNT_MAX = 12'hFFF;
  localparam logic [7:0]  LP_DEF_THR = 8'(DEF_THRESHOLD);
  localparam logic [1:0]  LP_DEF_MOD = 2'(DEF_MODE);

  // SYNC skips a frame already running at reset release.
  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_vsync_d;
  logic        r_href_d;
  logic [11:0] r_pix_cnt;
  logic [11:0] r_line_cnt;
  logic        r_err_acc;

  // cfg_ready doubles as "pending slot empty"
  logic        r_cfg_ready;
  logic [1:0]  r_pend_mode;
  logic [7:0]  r_pend_thr;

  logic [1:0]  r_act_mode;
  logic [7:0]  r_act_thr;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [15:0] r_frame_cnt;
  logic [11:0] r_last_lines;

  logic        w_fs;
  logic        w_fe;
  logic        w_hs;
  logic        w_he;
  logic        w_start;
  logic        w_end;
  logic        w_cfg_xfer;
  logic [11:0] w_pix_base;
  logic [11:0] w_pix_nxt;
  logic [11:0] w_line_nxt;
  logic        w_err_nxt;

  assign w_fs = bus.pre_frame_vsync & ~r_vsync_d;
  assign w_fe = ~bus.pre_frame_vsync & r_vsync_d;
  assign w_hs = bus.pre_frame_href & ~r_href_d;
  assign w_he = ~bus.pre_frame_href & r_href_d;

  assign w_cfg_xfer = bus.cfg_valid & r_cfg_ready;

  // Line start restarts the pixel count; a de in that same cycle still counts.
  assign w_pix_base = w_hs ? 12'd0 : r_pix_cnt;
  assign w_pix_nxt  = (bus.pre_frame_de && (w_pix_base != LP_CNT_MAX)) ?
                      (w_pix_base + 12'd1) : w_pix_base;
  // Closing line is folded in before frame status is taken (he with fe).
  assign w_line_nxt = (w_he && (r_line_cnt != LP_CNT_MAX)) ?
                      (r_line_cnt + 12'd1) : r_line_cnt;
  assign w_err_nxt  = r_err_acc | (w_he & (r_pix_cnt != LP_H));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SYNC;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and frame start/end strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (!bus.pre_frame_vsync) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_fs) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_fe) begin
          w_state_nxt = ST_IDLE;
          w_end       = 1'b1;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // Edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_href_d  <= 1'b0;
    end else begin
      r_vsync_d <= bus.pre_frame_vsync;
      r_href_d  <= bus.pre_frame_href;
    end
  end

  // Pending config slot: filled by a transfer, emptied at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_ready <= 1'b1;
      r_pend_mode <= 2'd0;
      r_pend_thr  <= 8'd0;
    end else begin
      if (w_cfg_xfer) begin
        r_cfg_ready <= 1'b0;
        r_pend_mode <= (bus.cfg_mode == 2'd3) ? 2'd2 : bus.cfg_mode;
        r_pend_thr  <= bus.cfg_threshold;
      end else if (w_start && !r_cfg_ready) begin
        r_cfg_ready <= 1'b1;
      end
    end
  end

  // Active config, timing counters and frame status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_mode   <= LP_DEF_MOD;
      r_act_thr    <= LP_DEF_THR;
      r_pix_cnt    <= 12'd0;
      r_line_cnt   <= 12'd0;
      r_err_acc    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= 16'd0;
      r_last_lines <= 12'd0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_start) begin
        if (!r_cfg_ready) begin
          r_act_mode <= r_pend_mode;
          r_act_thr  <= r_pend_thr;
        end
        r_pix_cnt  <= 12'd0;
        r_line_cnt <= 12'd0;
        r_err_acc  <= 1'b0;
      end else if (r_state == ST_ACTIVE) begin
        r_pix_cnt  <= w_pix_nxt;
        r_line_cnt <= w_line_nxt;
        r_err_acc  <= w_err_nxt;
        if (w_end) begin
          r_frame_done <= 1'b1;
          r_last_lines <= w_line_nxt;
          r_frame_err  <= w_err_nxt | (w_line_nxt != LP_V);
          r_frame_cnt  <= r_frame_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.cfg_ready     = r_cfg_ready;
  assign bus.act_mode      = r_act_mode;
  assign bus.act_threshold = r_act_thr;
  assign bus.frame_done    = r_frame_done;
  assign bus.frame_err     = r_frame_err;
  assign bus.frame_cnt     = r_frame_cnt;
  assign bus.last_lines    = r_last_lines;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Directed bench for vip_frame_ctrl with a small 8x6 frame geometry.
module tb_vip_frame_ctrl;
  localparam int H = 8;
  localparam int V = 6;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   pulses;

  vip_frame_ctrl_if bus ();

  vip_frame_ctrl #(
    .H_PIXELS(H), .V_LINES(V), .DEF_THRESHOLD(128), .DEF_MODE(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count frame_done pulses away from the active edge
  always @(negedge clk) if (bus.frame_done === 1'b1) pulses++;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_begin();
    bus.pre_frame_vsync = 1'b1;
    tick();
  endtask

  task automatic send_line(input int npix);
    bus.pre_frame_href = 1'b1;
    bus.pre_frame_de   = 1'b1;
    repeat (npix) tick();
    bus.pre_frame_href = 1'b0;
    bus.pre_frame_de   = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_end();
    bus.pre_frame_vsync = 1'b0;
    tick();
  endtask

  task automatic send_frame(input int nlines, input int short_idx);
    frame_begin();
    for (int l = 0; l < nlines; l++) send_line((l == short_idx) ? H - 1 : H);
    frame_end();
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (bus.act_mode !== 2'd2) begin bad++; $display("FAIL reset_act_mode: got %0d expected 2", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd128) begin bad++; $display("FAIL reset_act_thr: got %0d expected 128", bus.act_threshold); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b expected 0", bus.frame_done); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", bus.frame_err); end
    total++; if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", bus.frame_cnt); end
    total++; if (bus.last_lines !== 12'd0) begin bad++; $display("FAIL reset_lines: got %0d expected 0", bus.last_lines); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b expected 1", bus.cfg_ready); end
    total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_clean_frames();
    int p0;
    p0 = pulses;
    for (int f = 0; f < 3; f++) begin
      send_frame(V, -1);
      total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL clean_done%0d: got %0b expected 1", f, bus.frame_done); end
      tick();
      total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL clean_done_width%0d: got %0b expected 0", f, bus.frame_done); end
    end
    total++; if (pulses - p0 !== 3) begin bad++; $display("FAIL clean_pulses: got %0d expected 3", pulses - p0); end
    total++; if (bus.frame_cnt !== 16'd3) begin bad++; $display("FAIL clean_cnt: got %0d expected 3", bus.frame_cnt); end
    total++; if (bus.last_lines !== 12'd6) begin bad++; $display("FAIL clean_lines: got %0d expected 6", bus.last_lines); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL clean_err: got %0b expected 0", bus.frame_err); end
    total++; if (bus.act_mode !== 2'd2) begin bad++; $display("FAIL clean_mode: got %0d expected 2", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd128) begin bad++; $display("FAIL clean_thr: got %0d expected 128", bus.act_threshold); end
  endtask

  task automatic test_cfg_update();
    bus.cfg_valid = 1'b1; bus.cfg_mode = 2'd1; bus.cfg_threshold = 8'd60;
    tick();
    // a second request must stall while the slot is full
    bus.cfg_mode = 2'd0; bus.cfg_threshold = 8'd99;
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_ready_low: got %0b expected 0", bus.cfg_ready); end
    total++; if (bus.act_mode !== 2'd2) begin bad++; $display("FAIL cfg_old_mode: got %0d expected 2", bus.act_mode); end
    repeat (3) tick();
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_ready_hold: got %0b expected 0", bus.cfg_ready); end
    bus.cfg_valid = 1'b0;
    bus.pre_frame_vsync = 1'b1;
    total++; if (bus.act_threshold !== 8'd128) begin bad++; $display("FAIL cfg_thr_before_fs: got %0d expected 128", bus.act_threshold); end
    tick();
    total++; if (bus.act_mode !== 2'd1) begin bad++; $display("FAIL cfg_new_mode: got %0d expected 1", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd60) begin bad++; $display("FAIL cfg_new_thr: got %0d expected 60", bus.act_threshold); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready_back: got %0b expected 1", bus.cfg_ready); end
    total++; if (bus.dbg_state !== 2'd2) begin bad++; $display("FAIL cfg_state_active: got %0d expected 2", bus.dbg_state); end
    for (int l = 0; l < V; l++) send_line(H);
    frame_end();
    tick();
    total++; if (bus.frame_cnt !== 16'd4) begin bad++; $display("FAIL cfg_cnt: got %0d expected 4", bus.frame_cnt); end
  endtask

  task automatic test_short_line();
    send_frame(V, 2);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL shortline_err: got %0b expected 1", bus.frame_err); end
    total++; if (bus.last_lines !== 12'd6) begin bad++; $display("FAIL shortline_lines: got %0d expected 6", bus.last_lines); end
    tick();
    send_frame(V, -1);
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL shortline_recover: got %0b expected 0", bus.frame_err); end
    tick();
  endtask

  task automatic test_short_frame();
    send_frame(V - 1, -1);
    total++; if (bus.last_lines !== 12'd5) begin bad++; $display("FAIL shortframe_lines: got %0d expected 5", bus.last_lines); end
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL shortframe_err: got %0b expected 1", bus.frame_err); end
    total++; if (bus.frame_cnt !== 16'd7) begin bad++; $display("FAIL shortframe_cnt: got %0d expected 7", bus.frame_cnt); end
    tick();
  endtask

  task automatic test_cfg_alias();
    // request lands on the same edge as frame start with nothing pending
    bus.cfg_valid = 1'b1; bus.cfg_mode = 2'd3; bus.cfg_threshold = 8'd77;
    bus.pre_frame_vsync = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    total++; if (bus.act_mode !== 2'd1) begin bad++; $display("FAIL alias_same_fs_mode: got %0d expected 1", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd60) begin bad++; $display("FAIL alias_same_fs_thr: got %0d expected 60", bus.act_threshold); end
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL alias_pending: got %0b expected 0", bus.cfg_ready); end
    for (int l = 0; l < V; l++) send_line(H);
    frame_end();
    tick();
    frame_begin();
    total++; if (bus.act_mode !== 2'd2) begin bad++; $display("FAIL alias_mode: got %0d expected 2", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd77) begin bad++; $display("FAIL alias_thr: got %0d expected 77", bus.act_threshold); end
    for (int l = 0; l < V; l++) send_line(H);
    frame_end();
    total++; if (bus.frame_cnt !== 16'd9) begin bad++; $display("FAIL alias_cnt: got %0d expected 9", bus.frame_cnt); end
    tick();
  endtask

  task automatic test_he_fe_same_cycle();
    for (int v = 0; v < 2; v++) begin
      frame_begin();
      for (int l = 0; l < V - 1; l++) send_line(H);
      bus.pre_frame_href = 1'b1;
      bus.pre_frame_de   = 1'b1;
      repeat ((v == 0) ? H : H - 1) tick();
      bus.pre_frame_href  = 1'b0;
      bus.pre_frame_de    = 1'b0;
      bus.pre_frame_vsync = 1'b0;
      tick();
      total++; if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL hefe_done%0d: got %0b expected 1", v, bus.frame_done); end
      total++; if (bus.last_lines !== 12'd6) begin bad++; $display("FAIL hefe_lines%0d: got %0d expected 6", v, bus.last_lines); end
      total++; if (bus.frame_err !== 1'(v)) begin bad++; $display("FAIL hefe_err%0d: got %0b expected %0d", v, bus.frame_err, v); end
      tick();
    end
  endtask

  task automatic test_reset_midframe_pending();
    int p0;
    frame_begin();
    send_line(H);
    bus.cfg_valid = 1'b1; bus.cfg_mode = 2'd0; bus.cfg_threshold = 8'd5;
    tick();
    bus.cfg_valid = 1'b0;
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_pending_set: got %0b expected 0", bus.cfg_ready); end
    bus.pre_frame_href = 1'b1; bus.pre_frame_de = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.act_mode !== 2'd2) begin bad++; $display("FAIL rst_mid_mode: got %0d expected 2", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd128) begin bad++; $display("FAIL rst_mid_thr: got %0d expected 128", bus.act_threshold); end
    total++; if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_cnt: got %0d expected 0", bus.frame_cnt); end
    total++; if (bus.last_lines !== 12'd0) begin bad++; $display("FAIL rst_mid_lines: got %0d expected 0", bus.last_lines); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_err: got %0b expected 0", bus.frame_err); end
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %0b expected 1", bus.cfg_ready); end
    total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL rst_mid_state: got %0d expected 0", bus.dbg_state); end
    bus.pre_frame_href = 1'b0; bus.pre_frame_de = 1'b0;
    repeat (2) tick();
    // release while the frame is still running
    rst_n = 1'b1;
    p0 = pulses;
    for (int l = 0; l < V - 2; l++) send_line(H);
    total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL rst_sync_state: got %0d expected 0", bus.dbg_state); end
    frame_end();
    tick();
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL rst_partial_pulse: got %0d expected 0", pulses - p0); end
    total++; if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_partial_cnt: got %0d expected 0", bus.frame_cnt); end
    frame_begin();
    total++; if (bus.act_mode !== 2'd2) begin bad++; $display("FAIL rst_discard_mode: got %0d expected 2", bus.act_mode); end
    total++; if (bus.act_threshold !== 8'd128) begin bad++; $display("FAIL rst_discard_thr: got %0d expected 128", bus.act_threshold); end
    for (int l = 0; l < V; l++) send_line(H);
    frame_end();
    tick();
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL rst_first_pulse: got %0d expected 1", pulses - p0); end
    total++; if (bus.frame_cnt !== 16'd1) begin bad++; $display("FAIL rst_first_cnt: got %0d expected 1", bus.frame_cnt); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_first_err: got %0b expected 0", bus.frame_err); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pulses = 0;
    rst_n = 1'b0;
    bus.pre_frame_vsync = 1'b0;
    bus.pre_frame_href  = 1'b0;
    bus.pre_frame_de    = 1'b0;
    bus.cfg_valid       = 1'b0;
    bus.cfg_mode        = 2'd0;
    bus.cfg_threshold   = 8'd0;
    test_reset();
    test_clean_frames();
    test_cfg_update();
    test_short_line();
    test_short_frame();
    test_cfg_alias();
    test_he_fe_same_cycle();
    test_reset_midframe_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
